// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, polarity constants and helpers
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_PIPE_DLY = 2;
    localparam int DEF_CW       = 11;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    function automatic int span_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - en-gated shift register, DEPTH=0 is a wire
module vga_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        logic bypass_unused;
        assign bypass_unused = &{1'b0, clk, reset, en};
        assign dout = din;
    end else begin : g_stages
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        always_comb begin
            for (int i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
            if (en) begin
                stage_d[0] = din;
                for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
            end else begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - programmable VGA raster counters with delayed de/hsync/vsync
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = SYNC_ACTIVE_LOW,
    parameter logic VSYNC_POL = SYNC_ACTIVE_LOW,
    parameter int   PIPE_DLY  = DEF_PIPE_DLY,
    parameter int   CW        = DEF_CW
) (
    input  logic          pixel_clk,
    input  logic          reset,
    input  logic          en,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          active,
    output logic          frame_start,
    output logic          line_start,
    output logic          de,
    output logic          hsync,
    output logic          vsync
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        (2 ** CW) < max_int(H_TOTAL, V_TOTAL)) begin : g_bad_cfg
        $fatal(1, "vga_timing_gen: zero timing field or CW too narrow for totals");
    end

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_W  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_W  = CW'(V_ACTIVE);
    // Sync windows compared one bit wider so an end equal to 2^CW cannot wrap
    localparam logic [CW:0]   HS_START = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0]   HS_END   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0]   VS_START = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0]   VS_END   = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
            end else begin
                h_cnt_d = h_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    logic active_raw, hs_on, vs_on, hs_raw, vs_raw;

    always_comb begin
        active_raw = (h_cnt_q < H_ACT_W) && (v_cnt_q < V_ACT_W);
        hs_on      = ({1'b0, h_cnt_q} >= HS_START) && ({1'b0, h_cnt_q} < HS_END);
        vs_on      = ({1'b0, v_cnt_q} >= VS_START) && ({1'b0, v_cnt_q} < VS_END);
        hs_raw     = hs_on ? HSYNC_POL : ~HSYNC_POL;
        vs_raw     = vs_on ? VSYNC_POL : ~VSYNC_POL;
    end

    assign x           = h_cnt_q;
    assign y           = v_cnt_q;
    assign active      = active_raw;
    assign line_start  = en && (h_cnt_q == '0);
    assign frame_start = en && (h_cnt_q == '0) && (v_cnt_q == '0);

    logic [2:0] dly_out;

    vga_delay_line #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DLY),
        .RESET_VAL ({1'b0, ~HSYNC_POL, ~VSYNC_POL})
    ) u_dly (
        .clk   (pixel_clk),
        .reset (reset),
        .en    (en),
        .din   ({active_raw, hs_raw, vs_raw}),
        .dout  (dly_out)
    );

    assign de    = dly_out[2];
    assign hsync = dly_out[1];
    assign vsync = dly_out[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks on a default 640x480 and a tiny 7x6 raster
module tb_vga_timing_gen;

    logic        pixel_clk = 1'b0;
    logic        reset;
    logic        en_a, en_b;

    logic [10:0] x_a, y_a, x_b, y_b;
    logic        active_a, fs_a, ls_a, de_a, hs_a, vs_a;
    logic        active_b, fs_b, ls_b, de_b, hs_b, vs_b;

    int total = 0;
    int bad   = 0;

    always #5 pixel_clk = ~pixel_clk;

    vga_timing_gen u_dut_a (
        .pixel_clk   (pixel_clk),
        .reset       (reset),
        .en          (en_a),
        .x           (x_a),
        .y           (y_a),
        .active      (active_a),
        .frame_start (fs_a),
        .line_start  (ls_a),
        .de          (de_a),
        .hsync       (hs_a),
        .vsync       (vs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HSYNC_POL(1'b1), .PIPE_DLY (0)
    ) u_dut_b (
        .pixel_clk   (pixel_clk),
        .reset       (reset),
        .en          (en_b),
        .x           (x_b),
        .y           (y_b),
        .active      (active_b),
        .frame_start (fs_b),
        .line_start  (ls_b),
        .de          (de_b),
        .hsync       (hs_b),
        .vsync       (vs_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pixel_clk);
        @(negedge pixel_clk);
    endtask

    initial begin
        int ls_cnt, ls_first, ls_second, fs_cnt, fs_first, fs_second;
        int de_cnt, hs_cnt, hs_first, hs_last, vs_cnt, x_bad, de_bad, n;

        reset = 1'b1;
        en_a  = 1'b1;
        en_b  = 1'b1;
        repeat (3) @(posedge pixel_clk);
        @(negedge pixel_clk);
        chk("rst_x", x_a, 0);
        chk("rst_y", y_a, 0);
        chk("rst_active", active_a, 1);
        chk("rst_de", de_a, 0);
        chk("rst_hsync", hs_a, 1);
        chk("rst_vsync", vs_a, 1);
        chk("rst_frame_start", fs_a, 1);
        reset = 1'b0;

        // Default raster: two full lines from release
        ls_cnt = 0; ls_first = -1; ls_second = -1; fs_cnt = 0;
        de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; vs_cnt = 0; x_bad = 0;
        for (int c = 0; c < 1600; c++) begin
            if (x_a != 11'(c % 800)) x_bad++;
            if (ls_a) begin
                ls_cnt++;
                if (ls_cnt == 1) ls_first = c; else ls_second = c;
            end
            if (fs_a) fs_cnt++;
            if (de_a) de_cnt++;
            if (!vs_a) vs_cnt++;
            if (c < 800 && !hs_a) begin
                if (hs_first < 0) hs_first = c;
                hs_last = c;
                hs_cnt++;
            end
            step();
        end
        chk("a_x_sequence_bad", x_bad, 0);
        chk("a_line_start_count", ls_cnt, 2);
        chk("a_line_period", ls_second - ls_first, 800);
        chk("a_frame_start_count", fs_cnt, 1);
        chk("a_hsync_low_count", hs_cnt, 96);
        chk("a_hsync_first_low", hs_first, 658);
        chk("a_hsync_last_low", hs_last, 753);
        chk("a_de_count", de_cnt, 1280);
        chk("a_vsync_low_count", vs_cnt, 0);
        chk("a_y_after_2_lines", y_a, 2);

        // Asynchronous reset in the middle of a line
        repeat (300) step();
        chk("a_pre_rst_x", x_a, 300);
        chk("a_pre_rst_de", de_a, 1);
        reset = 1'b1;
        #1;
        chk("a_async_rst_x", x_a, 0);
        chk("a_async_rst_y", y_a, 0);
        chk("a_async_rst_de", de_a, 0);
        @(negedge pixel_clk);
        reset = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!(ls_a && x_a == 11'd0) && n < 2000);
        chk("a_post_rst_line_len", n, 800);
        chk("a_post_rst_y", y_a, 1);

        // Stall at start of line: line_start suppressed, state frozen
        en_a = 1'b0;
        #1;
        chk("a_stall_line_start", ls_a, 0);
        repeat (5) step();
        chk("a_stall_x", x_a, 0);
        chk("a_stall_y", y_a, 1);
        en_a = 1'b1;
        #1;
        chk("a_resume_line_start", ls_a, 1);

        // Tiny raster: 7 x 6, hsync active-high, no pipeline delay
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        fs_cnt = 0; fs_first = -1; fs_second = -1; hs_cnt = 0; x_bad = 0;
        vs_cnt = 0; de_cnt = 0; de_bad = 0;
        for (int c = 0; c < 84; c++) begin
            if (fs_b) begin
                fs_cnt++;
                if (fs_cnt == 1) fs_first = c; else fs_second = c;
            end
            if (hs_b) begin
                hs_cnt++;
                if (x_b != 11'd5) x_bad++;
            end
            if (!vs_b) vs_cnt++;
            if (de_b) de_cnt++;
            if (de_b != active_b) de_bad++;
            step();
        end
        chk("b_frame_start_count", fs_cnt, 2);
        chk("b_frame_period", fs_second - fs_first, 42);
        chk("b_hsync_high_count", hs_cnt, 12);
        chk("b_hsync_not_at_x5", x_bad, 0);
        chk("b_vsync_low_count", vs_cnt, 14);
        chk("b_de_count", de_cnt, 24);
        chk("b_de_vs_active_bad", de_bad, 0);

        // Stall exactly on the frame wrap cycle
        repeat (41) step();
        chk("b_wrap_x", x_b, 6);
        chk("b_wrap_y", y_b, 5);
        en_b = 1'b0;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            if (fs_b || ls_b) n++;
            step();
        end
        chk("b_stall_pulses", n, 0);
        chk("b_stall_x", x_b, 6);
        chk("b_stall_y", y_b, 5);
        chk("b_stall_hsync", hs_b, 0);
        chk("b_stall_vsync", vs_b, 1);
        en_b = 1'b1;
        step();
        chk("b_resume_x", x_b, 0);
        chk("b_resume_y", y_b, 0);
        chk("b_resume_frame_start", fs_b, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
